// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing generator scanning a 4x-upscaled framebuffer out of VRAM.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int FB_WIDTH = 160
) (
  input  logic        clk,
  input  logic        RST,
  output logic [15:0] vram_rd_addr_o,
  output logic        vram_re_o,
  input  logic [11:0] vram_rd_data_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [3:0]  vgaRed_o,
  output logic [3:0]  vgaGreen_o,
  output logic [3:0]  vgaBlue_o,
  output logic        frame_start_o,
  output logic        in_vblank_o
);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] V_VIS_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + 159);
  localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + 44);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + 16);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + 111);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + 10);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + 11);
  logic        pix_en;
  logic        active;
  logic        h_end;
  logic        v_end;
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [15:0] row_base;
  // FB_WIDTH is constant, so this unrolls into a fixed sum of shifted rows
  always_comb begin
    row_base = '0;
    for (int i = 0; i < 16; i++)
      row_base = FB_WIDTH[i] ? row_base + ({8'd0, vcnt[9:2]} << i) : row_base;
  end
  assign active         = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign h_end          = hcnt == H_LAST;
  assign v_end          = vcnt == V_LAST;
  assign vram_rd_addr_o = active ? row_base + {8'd0, hcnt[9:2]} : '0;
  assign vram_re_o      = active & ~RST;
  assign in_vblank_o    = vcnt >= V_VIS;
  // VRAM data for the current pixel arrives mid-period, so it is latched as the counters advance
  always_ff @(posedge clk) begin
    if (RST) begin
      pix_en        <= 1'b0;
      hcnt          <= '0;
      vcnt          <= '0;
      hsync_o       <= 1'b1;
      vsync_o       <= 1'b1;
      vgaRed_o      <= '0;
      vgaGreen_o    <= '0;
      vgaBlue_o     <= '0;
      frame_start_o <= 1'b0;
    end else begin
      pix_en        <= ~pix_en;
      frame_start_o <= pix_en && h_end && vcnt == V_VIS_LAST;
      if (pix_en) begin
        hcnt    <= h_end ? '0 : hcnt + 10'd1;
        vcnt    <= h_end ? (v_end ? '0 : vcnt + 10'd1) : vcnt;
        hsync_o <= !(hcnt >= HS_FIRST && hcnt <= HS_LAST);
        vsync_o <= !(vcnt >= VS_FIRST && vcnt <= VS_LAST);
        {vgaRed_o, vgaGreen_o, vgaBlue_o} <= active ? vram_rd_data_i : 12'd0;
      end
    end
  end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: checks a full-size instance for line/address/colour timing and a small one for frame timing.
module tb_vga_scanout;
  localparam int HA_A = 640, VA_A = 480, FW_A = 160, HT_A = 800, VT_A = 525;
  localparam int HA_B = 16, VA_B = 8, FW_B = 4, HT_B = 176, VT_B = 53;
  localparam int FRAME_B = 2 * HT_B * VT_B;
  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1;
  logic [15:0] addr_a, addr_b;
  logic re_a, re_b, hs_a, hs_b, vs_a, vs_b, fs_a, fs_b, vb_a, vb_b;
  logic [11:0] data_a = '0, data_b = '0;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  int na = 0, nb = 0;
  int tests = 0, fails = 0;
  typedef struct {int due; logic [11:0] rgb;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  vga_scanout #(.H_ACTIVE(HA_A), .V_ACTIVE(VA_A), .FB_WIDTH(FW_A)) dut_a (
    .clk(clk), .RST(rst_a), .vram_rd_addr_o(addr_a), .vram_re_o(re_a), .vram_rd_data_i(data_a),
    .hsync_o(hs_a), .vsync_o(vs_a), .vgaRed_o(r_a), .vgaGreen_o(g_a), .vgaBlue_o(b_a),
    .frame_start_o(fs_a), .in_vblank_o(vb_a));
  vga_scanout #(.H_ACTIVE(HA_B), .V_ACTIVE(VA_B), .FB_WIDTH(FW_B)) dut_b (
    .clk(clk), .RST(rst_b), .vram_rd_addr_o(addr_b), .vram_re_o(re_b), .vram_rd_data_i(data_b),
    .hsync_o(hs_b), .vsync_o(vs_b), .vgaRed_o(r_b), .vgaGreen_o(g_b), .vgaBlue_o(b_b),
    .frame_start_o(fs_b), .in_vblank_o(vb_b));
  // VRAM model: data is the low 12 address bits, one clk late; cycle counters since reset release
  always @(posedge clk) begin
    data_a <= addr_a[11:0];
    data_b <= addr_b[11:0];
    na <= rst_a ? 0 : na + 1;
    nb <= rst_b ? 0 : nb + 1;
  end
  function automatic int ph(int n, int ht);
    return (n / 2) % ht;
  endfunction
  function automatic int pv(int n, int ht, int vt);
    return (n / 2 / ht) % vt;
  endfunction
  function automatic logic [15:0] maddr(int h, int v, int ha, int va, int fw);
    return (h < ha && v < va) ? 16'((v / 4) * fw + h / 4) : 16'd0;
  endfunction
  task automatic release_a();
    rst_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
  endtask
  task automatic release_b();
    rst_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
  endtask
  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    tests += 7;
    if (hs_a !== 1'b1) begin fails++; $display("FAIL reset_hsync got %b exp 1", hs_a); end
    if (vs_a !== 1'b1) begin fails++; $display("FAIL reset_vsync got %b exp 1", vs_a); end
    if ({r_a, g_a, b_a} !== 12'd0) begin fails++; $display("FAIL reset_colour got %h exp 000", {r_a, g_a, b_a}); end
    if (fs_a !== 1'b0) begin fails++; $display("FAIL reset_frame_start got %b exp 0", fs_a); end
    if (re_a !== 1'b0) begin fails++; $display("FAIL reset_re got %b exp 0", re_a); end
    if (vb_a !== 1'b0) begin fails++; $display("FAIL reset_vblank got %b exp 0", vb_a); end
    if (re_b !== 1'b0) begin fails++; $display("FAIL reset_re_b got %b exp 0", re_b); end
  endtask
  task automatic test_line_timing(input string tag);
    int fall1 = -1, rise1 = -1, fall2 = -1;
    logic prev = 1'b1;
    for (int c = 0; c < 3300; c++) begin
      @(negedge clk);
      if (prev && !hs_a) begin
        if (fall1 < 0) fall1 = na;
        else if (fall2 < 0) fall2 = na;
      end
      if (!prev && hs_a && rise1 < 0) rise1 = na;
      prev = hs_a;
    end
    tests += 3;
    if (fall1 !== 1314) begin fails++; $display("FAIL %s hsync_fall got %0d exp 1314", tag, fall1); end
    if (rise1 - fall1 !== 192) begin fails++; $display("FAIL %s hsync_low got %0d exp 192", tag, rise1 - fall1); end
    if (fall2 - fall1 !== 1600) begin fails++; $display("FAIL %s hsync_period got %0d exp 1600", tag, fall2 - fall1); end
  endtask
  task automatic test_addressing();
    int h, v;
    for (int c = 0; c < 20000 && na < 2 * (9 * HT_A + 700); c++) begin
      @(negedge clk);
      h = ph(na, HT_A);
      v = pv(na, HT_A, VT_A);
      tests += 2;
      if (addr_a !== maddr(h, v, HA_A, VA_A, FW_A)) begin
        fails++; $display("FAIL addr (%0d,%0d) got %0d exp %0d", h, v, addr_a, maddr(h, v, HA_A, VA_A, FW_A));
      end
      if (re_a !== (h < HA_A && v < VA_A)) begin fails++; $display("FAIL re (%0d,%0d) got %b", h, v, re_a); end
      if (v == 9 && h == 5) begin
        tests++;
        if (addr_a !== 16'd321 || re_a !== 1'b1) begin fails++; $display("FAIL addr_5_9 got %0d/%b exp 321/1", addr_a, re_a); end
      end
      if (v == 9 && h == 639) begin
        tests++;
        if (addr_a !== 16'd479) begin fails++; $display("FAIL addr_639_9 got %0d exp 479", addr_a); end
      end
      if (v == 9 && h == 640) begin
        tests++;
        if (addr_a !== 16'd0 || re_a !== 1'b0) begin fails++; $display("FAIL addr_640_9 got %0d/%b exp 0/0", addr_a, re_a); end
      end
    end
  endtask
  task automatic test_colour();
    int h, v;
    logic [15:0] a;
    release_a();
    sb.delete();
    for (int c = 0; c < 2 * 3 * HT_A; c++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due == na) begin
        tests++;
        if ({r_a, g_a, b_a} !== sb[0].rgb) begin
          fails++; $display("FAIL colour n=%0d got %h exp %h", na, {r_a, g_a, b_a}, sb[0].rgb);
        end
        void'(sb.pop_front());
      end
      h = ph(na, HT_A);
      v = pv(na, HT_A, VT_A);
      a = maddr(h, v, HA_A, VA_A, FW_A);
      sb.push_back('{na + 2, a[11:0]});
      if (na == 2 * 8 + 2) begin
        tests++;
        if ({r_a, g_a, b_a} !== 12'h002) begin fails++; $display("FAIL colour_8_0 got %h exp 002", {r_a, g_a, b_a}); end
      end
      if (na == 2 * 700 + 2) begin
        tests++;
        if ({r_a, g_a, b_a} !== 12'h000) begin fails++; $display("FAIL colour_blank got %h exp 000", {r_a, g_a, b_a}); end
      end
    end
    sb.delete();
  endtask
  task automatic test_mid_reset();
    release_b();
    while (nb < 2 * (HT_B * 19 + 50)) @(negedge clk);
    tests++;
    if (vs_b !== 1'b0) begin fails++; $display("FAIL pre_reset_vsync got %b exp 0", vs_b); end
    rst_b = 1'b1;
    #1;
    tests++;
    if (re_b !== 1'b0) begin fails++; $display("FAIL mid_reset_re got %b exp 0", re_b); end
    @(negedge clk);
    tests += 3;
    if (vs_b !== 1'b1) begin fails++; $display("FAIL mid_reset_vsync got %b exp 1", vs_b); end
    if (hs_b !== 1'b1) begin fails++; $display("FAIL mid_reset_hsync got %b exp 1", hs_b); end
    if ({r_b, g_b, b_b} !== 12'd0) begin fails++; $display("FAIL mid_reset_colour got %h exp 000", {r_b, g_b, b_b}); end
    rst_b = 1'b0;
    while (na < 2 * (HT_A * 5 + 300)) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    tests += 3;
    if (hs_a !== 1'b1) begin fails++; $display("FAIL mid_reset_hsync_a got %b exp 1", hs_a); end
    if ({r_a, g_a, b_a} !== 12'd0) begin fails++; $display("FAIL mid_reset_colour_a got %h exp 000", {r_a, g_a, b_a}); end
    if (fs_a !== 1'b0) begin fails++; $display("FAIL mid_reset_fs_a got %b exp 0", fs_a); end
    rst_a = 1'b0;
    test_line_timing("after_reset");
  endtask
  task automatic test_frame();
    int pulses = 0, p1 = -1, p2 = -1, vfall = -1, vrise = -1, h, v;
    logic prev_fs = 1'b0, prev_vb = 1'b0, prev_vs = 1'b1;
    release_b();
    for (int c = 0; c < 2 * FRAME_B + 200; c++) begin
      @(negedge clk);
      h = ph(nb, HT_B);
      v = pv(nb, HT_B, VT_B);
      tests += 2;
      if (addr_b !== maddr(h, v, HA_B, VA_B, FW_B) || addr_b > 16'd7) begin
        fails++; $display("FAIL addr_b (%0d,%0d) got %0d exp %0d", h, v, addr_b, maddr(h, v, HA_B, VA_B, FW_B));
      end
      if (vb_b !== (v >= VA_B)) begin fails++; $display("FAIL vblank_b (%0d,%0d) got %b", h, v, vb_b); end
      if (h == 15 && v == 7) begin
        tests++;
        if (addr_b !== 16'd7) begin fails++; $display("FAIL addr_max got %0d exp 7", addr_b); end
      end
      if (fs_b) begin
        pulses++;
        if (p1 < 0) p1 = nb; else if (p2 < 0) p2 = nb;
        tests += 2;
        if (prev_fs !== 1'b0) begin fails++; $display("FAIL fs_width at n=%0d got wide pulse exp 1 clk", nb); end
        if (!(vb_b && !prev_vb)) begin fails++; $display("FAIL fs_vblank_align at n=%0d got vb %b->%b exp 0->1", nb, prev_vb, vb_b); end
      end
      if (prev_vs && !vs_b && vfall < 0) vfall = nb;
      if (!prev_vs && vs_b && vrise < 0) vrise = nb;
      prev_fs = fs_b;
      prev_vb = vb_b;
      prev_vs = vs_b;
    end
    tests += 5;
    if (pulses !== 2) begin fails++; $display("FAIL fs_count got %0d exp 2", pulses); end
    if (p1 !== 2 * HT_B * VA_B) begin fails++; $display("FAIL fs_first got %0d exp %0d", p1, 2 * HT_B * VA_B); end
    if (p2 - p1 !== FRAME_B) begin fails++; $display("FAIL fs_period got %0d exp %0d", p2 - p1, FRAME_B); end
    if (vfall !== 2 * HT_B * (VA_B + 10) + 2) begin fails++; $display("FAIL vsync_fall got %0d exp %0d", vfall, 2 * HT_B * (VA_B + 10) + 2); end
    if (vrise - vfall !== 4 * HT_B) begin fails++; $display("FAIL vsync_low got %0d exp %0d", vrise - vfall, 4 * HT_B); end
  endtask
  initial begin
    test_reset();
    release_a();
    test_line_timing("line");
    test_addressing();
    test_colour();
    test_mid_reset();
    test_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
